// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// Multiplies settle in one extra cycle; divides run a 32-step restoring divider.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] product,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        op_mul, op_div, last;
  logic [63:0] mul_a, mul_b;
  logic [32:0] rem_sh, diff, rem_nx;
  logic [31:0] quo_nx, q_fin, r_fin;

  assign op_mul  = is_mult | is_multu;
  assign op_div  = is_div | is_divu;
  assign last    = (state_q == MUL) | ((state_q == DIV) & (cnt_q == 5'd31));
  assign busy    = ((state_q == IDLE) & start & ~flush & (op_mul | op_div)) |
                   ((state_q != IDLE) & ~last & ~flush);
  assign product = prod_q[31:0];
  assign hi      = hi_q;
  assign lo      = lo_q;

  // One 64x64 multiplier serves both flavours; sign extension selects signed.
  assign mul_a = {{32{is_mult & src_a[31]}}, src_a};
  assign mul_b = {{32{is_mult & src_b[31]}}, src_b};

  // quo_q starts as the dividend and fills with quotient bits from the LSB.
  always_comb begin
    rem_sh = {rem_q[31:0], quo_q[31]};
    diff   = rem_sh - {1'b0, dvsr_q};
    rem_nx = diff[32] ? rem_sh : diff;
    quo_nx = {quo_q[30:0], ~diff[32]};
    q_fin  = (sgn_q & qneg_q) ? -quo_nx : quo_nx;
    r_fin  = (sgn_q & rneg_q) ? -rem_nx[31:0] : rem_nx[31:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      IDLE: begin
        if (start & ~flush) begin
          if (op_mul) begin
            state_d = MUL;
            prod_d  = mul_a * mul_b;
          end else if (op_div) begin
            state_d = DIV;
            sgn_d   = is_div;
            qneg_d  = src_a[31] ^ src_b[31];
            rneg_d  = src_a[31];
            quo_d   = (is_div & src_a[31]) ? -src_a : src_a;
            dvsr_d  = (is_div & src_b[31]) ? -src_b : src_b;
            cnt_d   = '0;
            rem_d   = '0;
          end else begin
            if (hi_wen) hi_d = src_a;
            if (lo_wen) lo_d = src_a;
          end
        end
      end
      MUL: begin
        state_d = IDLE;
        hi_d    = prod_q[63:32];
        lo_d    = prod_q[31:0];
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          lo_d    = q_fin;
          hi_d    = r_fin;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: expected HI/LO pushed at issue, popped at completion.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_mult = 1'b0, is_multu = 1'b0, is_div = 1'b0, is_divu = 1'b0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0, flush = 1'b0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy;
  logic [31:0] product, hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam int K_MULT = 0, K_MULTU = 1, K_DIV = 2, K_DIVU = 3;

  hilo_muldiv dut (
    .clk(clk), .reset(reset), .start(start),
    .is_mult(is_mult), .is_multu(is_multu), .is_div(is_div), .is_divu(is_divu),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .product(product), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sb, q, m;
    logic [63:0] p;
    logic [31:0] qq, rr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (kind)
      K_MULT:  begin p = 64'(sa * sb); r = p; end
      K_MULTU: begin p = {32'd0, a} * {32'd0, b}; r = p; end
      K_DIV: begin
        if (b == 32'd0) begin
          qq = 32'hFFFFFFFF;
          rr = a[31] ? -a : a;
          if (a[31]) begin qq = -qq; rr = -rr; end
          r.hi = rr; r.lo = qq;
        end else begin
          q = sa / sb; m = sa % sb;
          r.hi = m[31:0]; r.lo = q[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin r.hi = a; r.lo = 32'hFFFFFFFF; end
        else begin r.hi = a % b; r.lo = a / b; end
      end
    endcase
    return r;
  endfunction

  task automatic clr_ctl;
    start = 1'b0; is_mult = 1'b0; is_multu = 1'b0; is_div = 1'b0; is_divu = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0; flush = 1'b0;
  endtask

  task automatic set_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; src_a = a; src_b = b;
    is_mult = (kind == K_MULT); is_multu = (kind == K_MULTU);
    is_div = (kind == K_DIV); is_divu = (kind == K_DIVU);
  endtask

  task automatic run_op(input string name, input int kind, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    int nb, want_nb;
    exp_t got_e;
    logic [31:0] want_prod;
    sb_q.push_back(e);
    want_nb   = (kind == K_MULT || kind == K_MULTU) ? 1 : 32;
    want_prod = e.lo;
    nb = 0;
    @(negedge clk); set_op(kind, a, b); #1;
    while (busy === 1'b1 && nb < 100) begin
      nb++;
      @(negedge clk); #1;
    end
    n_cmp++;
    if (nb !== want_nb) begin
      n_err++; $display("FAIL %s busy_cycles got %0d want %0d", name, nb, want_nb);
    end
    if (want_nb == 1) begin
      n_cmp++;
      if (product !== want_prod) begin
        n_err++; $display("FAIL %s product got %h want %h", name, product, want_prod);
      end
    end
    @(negedge clk); clr_ctl; #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL %s retrigger_busy got %b want 0", name, busy);
    end
    got_e = sb_q.pop_front();
    n_cmp++;
    if (hi !== got_e.hi) begin
      n_err++; $display("FAIL %s hi got %h want %h", name, hi, got_e.hi);
    end
    n_cmp++;
    if (lo !== got_e.lo) begin
      n_err++; $display("FAIL %s lo got %h want %h", name, lo, got_e.lo);
    end
    cur = got_e;
  endtask

  task automatic test_reset;
    @(negedge clk); reset = 1'b1; clr_ctl;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++;
    if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++;
    if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
    n_cmp++;
    if (product !== 32'h0) begin n_err++; $display("FAIL reset_product got %h want 0", product); end
    reset = 1'b0;
    cur = '0;
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk); start = 1'b1; hi_wen = 1'b1; src_a = 32'h12345678; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy got %b want 0", busy); end
    @(negedge clk); hi_wen = 1'b0; lo_wen = 1'b1; src_a = 32'h9ABCDEF0; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mtlo_busy got %b want 0", busy); end
    n_cmp++;
    if (hi !== 32'h12345678) begin n_err++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    @(negedge clk); clr_ctl; #1;
    n_cmp++;
    if (lo !== 32'h9ABCDEF0) begin n_err++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo); end
    n_cmp++;
    if (hi !== 32'h12345678) begin n_err++; $display("FAIL mtlo_hi_kept got %h want 12345678", hi); end
    cur = '{hi: 32'h12345678, lo: 32'h9ABCDEF0};
  endtask

  task automatic test_mul;
    run_op("mult_m2x3", K_MULT, 32'hFFFFFFFE, 32'h3, '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFA});
    run_op("multu_m2x3", K_MULTU, 32'hFFFFFFFE, 32'h3, '{hi: 32'h00000002, lo: 32'hFFFFFFFA});
  endtask

  task automatic test_div;
    run_op("divu_100_7", K_DIVU, 32'd100, 32'd7, '{hi: 32'd2, lo: 32'd14});
    run_op("div_m7_2", K_DIV, 32'hFFFFFFF9, 32'd2, '{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD});
    run_op("divu_by_zero", K_DIVU, 32'h80000000, 32'd0, '{hi: 32'h80000000, lo: 32'hFFFFFFFF});
  endtask

  task automatic test_flush;
    @(negedge clk); set_op(K_DIV, 32'd100, 32'd7); #1;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL flush_issue_busy got %b want 1", busy); end
    for (int i = 0; i < 11; i++) @(negedge clk);
    flush = 1'b1; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL flush_cycle_busy got %b want 0", busy); end
    @(negedge clk); clr_ctl; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL flush_after_busy got %b want 0", busy); end
    n_cmp++;
    if (hi !== cur.hi) begin n_err++; $display("FAIL flush_hi got %h want %h", hi, cur.hi); end
    n_cmp++;
    if (lo !== cur.lo) begin n_err++; $display("FAIL flush_lo got %h want %h", lo, cur.lo); end
    run_op("divu_after_flush", K_DIVU, 32'd1000, 32'd9, '{hi: 32'd1, lo: 32'd111});
  endtask

  task automatic test_random;
    int kind;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(3, 0));
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      if (i == 6) begin kind = K_DIV; a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op($sformatf("rand%0d_k%0d", i, kind), kind, a, b, model(kind, a, b));
    end
  endtask

  task automatic test_reset_mid_div;
    @(negedge clk); set_op(K_DIVU, 32'd12345, 32'd17);
    for (int i = 0; i < 6; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; clr_ctl; #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++;
    if (hi !== 32'h0) begin n_err++; $display("FAIL rstmid_hi got %h want 0", hi); end
    n_cmp++;
    if (lo !== 32'h0) begin n_err++; $display("FAIL rstmid_lo got %h want 0", lo); end
    cur = '0;
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_mul;
    test_div;
    test_flush;
    test_random;
    test_reset_mid_div;
    run_op("div_after_reset", K_DIV, 32'd50, 32'hFFFFFFF9, model(K_DIV, 32'd50, 32'hFFFFFFF9));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
